// File: rtl/exc_pkg.sv
// Shared definitions for the commit-stage exception arbiter: exception flag
// bit map, MIPS ExcCodes, FSM states and the per-lane resolved-exception record.
package exc_pkg;

    localparam int EXC_IF_ADEL = 7;
    localparam int EXC_SYS     = 6;
    localparam int EXC_BP      = 5;
    localparam int EXC_ERET    = 4;
    localparam int EXC_RI      = 3;
    localparam int EXC_OV      = 2;
    localparam int EXC_LD_ADEL = 1;
    localparam int EXC_ST_ADES = 0;

    localparam logic [4:0] CODE_INT  = 5'h00;
    localparam logic [4:0] CODE_ADEL = 5'h04;
    localparam logic [4:0] CODE_ADES = 5'h05;
    localparam logic [4:0] CODE_SYS  = 5'h08;
    localparam logic [4:0] CODE_BP   = 5'h09;
    localparam logic [4:0] CODE_RI   = 5'h0a;
    localparam logic [4:0] CODE_OV   = 5'h0c;
    localparam logic [4:0] CODE_ERET = 5'h0e;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } exc_state_t;

    typedef struct packed {
        logic [4:0]  code;
        logic [31:0] epc;
        logic [31:0] bad_addr;
        logic        bad_we;
        logic        bd;
        logic [31:0] target;
    } exc_info_t;

    // A delay-slot instruction restarts at its branch, one word earlier.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/exc_lane_decode.sv
// Per-lane exception priority encoder: turns one lane's flags (plus an attached
// interrupt) into a hit bit and the full exception record for that lane.
module exc_lane_decode
    import exc_pkg::*;
#(
    parameter int          EXC_W      = 8,
    parameter logic [31:0] VEC_BEV    = 32'hBFC00380,
    parameter logic [31:0] VEC_NORMAL = 32'h80000180
) (
    input  logic             valid,
    input  logic             int_attach,
    input  logic [EXC_W-1:0] except,
    input  logic             in_delayslot,
    input  logic [31:0]      pc,
    input  logic [31:0]      daddr,
    input  logic [31:0]      cp0_epc,
    input  logic             bev,
    output logic             hit,
    output exc_info_t        info
);

    always_comb begin
        hit           = 1'b0;
        info          = '0;
        info.epc      = epc_of(pc, in_delayslot);
        info.bd       = in_delayslot;
        info.target   = bev ? VEC_BEV : VEC_NORMAL;
        if (valid) begin
            hit = 1'b1;
            if (int_attach) begin
                info.code = CODE_INT;
            end else if (except[EXC_IF_ADEL]) begin
                info.code     = CODE_ADEL;
                info.bad_addr = pc;
                info.bad_we   = 1'b1;
            end else if (except[EXC_LD_ADEL]) begin
                info.code     = CODE_ADEL;
                info.bad_addr = daddr;
                info.bad_we   = 1'b1;
            end else if (except[EXC_ST_ADES]) begin
                info.code     = CODE_ADES;
                info.bad_addr = daddr;
                info.bad_we   = 1'b1;
            end else if (except[EXC_SYS]) begin
                info.code = CODE_SYS;
            end else if (except[EXC_BP]) begin
                info.code = CODE_BP;
            end else if (except[EXC_ERET]) begin
                // ERET returns through EPC instead of entering the handler.
                info.code   = CODE_ERET;
                info.target = cp0_epc;
            end else if (except[EXC_RI]) begin
                info.code = CODE_RI;
            end else if (except[EXC_OV]) begin
                info.code = CODE_OV;
            end else begin
                hit = 1'b0;
            end
        end
    end

endmodule

// File: rtl/exception_arbiter_n.sv
// Commit-stage exception arbiter: picks the oldest faulting lane, kills it and
// all younger lanes, and holds the resolved exception until redirect accepts it.
module exception_arbiter_n
    import exc_pkg::*;
#(
    parameter int          NUM_LANES  = 2,
    parameter int          EXC_W      = 8,
    parameter logic [31:0] VEC_BEV    = 32'hBFC00380,
    parameter logic [31:0] VEC_NORMAL = 32'h80000180,
    localparam int         LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_LANES-1:0]       lane_valid,
    input  logic [NUM_LANES-1:0]       lane_in_delayslot,
    input  logic [NUM_LANES*EXC_W-1:0] lane_except,
    input  logic [NUM_LANES*32-1:0]    lane_pc,
    input  logic [NUM_LANES*32-1:0]    lane_daddr,
    input  logic [31:0]                cp0_status,
    input  logic [31:0]                cp0_cause,
    input  logic [31:0]                cp0_epc,
    input  logic                       redirect_ready,
    output logic [NUM_LANES-1:0]       lane_kill,
    output logic                       busy,
    output logic                       except_valid,
    output logic [4:0]                 except_code,
    output logic [LANE_W-1:0]          except_lane,
    output logic [31:0]                except_inst_addr,
    output logic [31:0]                except_epc,
    output logic [31:0]                except_bad_addr,
    output logic                       except_bad_addr_we,
    output logic                       except_in_delayslot,
    output logic [31:0]                except_target
);

    exc_state_t             state;
    exc_state_t             state_next;
    logic                   int_req_q;
    logic                   int_req_d;
    logic [NUM_LANES-1:0]   int_attach;
    logic [NUM_LANES-1:0]   hit;
    exc_info_t              info [NUM_LANES];
    logic                   win_found;
    logic [LANE_W-1:0]      win_lane;
    exc_info_t              win_info;
    logic [31:0]            win_pc;
    logic                   capture;
    logic                   complete;
    logic                   unused_cp0;

    assign unused_cp0 = ^{cp0_status[31:23], cp0_status[21:16], cp0_status[7:2],
                          cp0_cause[31:16], cp0_cause[7:0]};

    // Pending, unmasked interrupt with EXL clear and IE set.
    assign int_req_d = ((cp0_cause[15:8] & cp0_status[15:8]) != 8'h00)
                       && !cp0_status[1] && cp0_status[0];

    // The lowest valid lane with every older lane valid can only be lane 0;
    // the decoder gates the attachment with the lane's own valid bit.
    always_comb begin
        int_attach    = '0;
        int_attach[0] = int_req_q;
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        exc_lane_decode #(
            .EXC_W      (EXC_W),
            .VEC_BEV    (VEC_BEV),
            .VEC_NORMAL (VEC_NORMAL)
        ) u_decode (
            .valid        (lane_valid[g]),
            .int_attach   (int_attach[g]),
            .except       (lane_except[g*EXC_W +: EXC_W]),
            .in_delayslot (lane_in_delayslot[g]),
            .pc           (lane_pc[g*32 +: 32]),
            .daddr        (lane_daddr[g*32 +: 32]),
            .cp0_epc      (cp0_epc),
            .bev          (cp0_status[22]),
            .hit          (hit[g]),
            .info         (info[g])
        );
    end

    // Scan from youngest to oldest so the oldest hit lands last and wins.
    always_comb begin
        win_found = 1'b0;
        win_lane  = '0;
        win_info  = '0;
        win_pc    = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_found = 1'b1;
                win_lane  = LANE_W'(i);
                win_info  = info[i];
                win_pc    = lane_pc[i*32 +: 32];
            end
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        lane_kill  = '0;
        capture    = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (win_found && resetn) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                    for (int j = 0; j < NUM_LANES; j++) begin
                        lane_kill[j] = (j >= int'(win_lane));
                    end
                end
            end
            HOLD: begin
                busy = 1'b1;
                if (redirect_ready) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            int_req_q <= 1'b0;
        end else begin
            state     <= state_next;
            int_req_q <= int_req_d;
        end
    end

    // Only except_valid drops on completion; the record stays for debug.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            except_valid        <= 1'b0;
            except_code         <= '0;
            except_lane         <= '0;
            except_inst_addr    <= '0;
            except_epc          <= '0;
            except_bad_addr     <= '0;
            except_bad_addr_we  <= 1'b0;
            except_in_delayslot <= 1'b0;
            except_target       <= '0;
        end else if (capture) begin
            except_valid        <= 1'b1;
            except_code         <= win_info.code;
            except_lane         <= win_lane;
            except_inst_addr    <= win_pc;
            except_epc          <= win_info.epc;
            except_bad_addr     <= win_info.bad_addr;
            except_bad_addr_we  <= win_info.bad_we;
            except_in_delayslot <= win_info.bd;
            except_target       <= win_info.target;
        end else if (complete) begin
            except_valid        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exception_arbiter_n.sv
// Bench for exception_arbiter_n: a 2-lane and a 4-lane instance share stimulus
// and are compared every cycle against a table-driven reference model.
module tb_exception_arbiter_n;

    logic         clk = 1'b0;
    logic         resetn;
    logic [3:0]   lane_valid;
    logic [3:0]   lane_ds;
    logic [31:0]  lane_exc;
    logic [127:0] lane_pc;
    logic [127:0] lane_daddr;
    logic [31:0]  cp0_status;
    logic [31:0]  cp0_cause;
    logic [31:0]  cp0_epc;
    logic         redirect_ready;

    logic [1:0]  kill2;
    logic        busy2, ev2, we2, bd2;
    logic [4:0]  code2;
    logic [0:0]  lane2;
    logic [31:0] ia2, epc2, bad2, tgt2;

    logic [3:0]  kill4;
    logic        busy4, ev4, we4, bd4;
    logic [4:0]  code4;
    logic [1:0]  lane4;
    logic [31:0] ia4, epc4, bad4, tgt4;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] VB = 32'hBFC00380;
    localparam logic [31:0] VN = 32'h80000180;

    // Priority table, highest first, after the interrupt: flag bit and ExcCode.
    int pri_bit[8]  = '{7, 1, 0, 6, 5, 4, 3, 2};
    int pri_code[8] = '{4, 4, 5, 8, 9, 14, 10, 12};

    bit          m_int;
    bit          m_hold[2];
    bit          m_valid[2];
    int          m_code[2];
    int          m_lane[2];
    logic [31:0] m_pc[2], m_epc[2], m_bad[2], m_tgt[2];
    bit          m_we[2], m_bd[2];

    always #5 clk = ~clk;

    exception_arbiter_n #(.NUM_LANES(2)) u_dut2 (
        .clk                 (clk),
        .resetn              (resetn),
        .lane_valid          (lane_valid[1:0]),
        .lane_in_delayslot   (lane_ds[1:0]),
        .lane_except         (lane_exc[15:0]),
        .lane_pc             (lane_pc[63:0]),
        .lane_daddr          (lane_daddr[63:0]),
        .cp0_status          (cp0_status),
        .cp0_cause           (cp0_cause),
        .cp0_epc             (cp0_epc),
        .redirect_ready      (redirect_ready),
        .lane_kill           (kill2),
        .busy                (busy2),
        .except_valid        (ev2),
        .except_code         (code2),
        .except_lane         (lane2),
        .except_inst_addr    (ia2),
        .except_epc          (epc2),
        .except_bad_addr     (bad2),
        .except_bad_addr_we  (we2),
        .except_in_delayslot (bd2),
        .except_target       (tgt2)
    );

    exception_arbiter_n #(.NUM_LANES(4)) u_dut4 (
        .clk                 (clk),
        .resetn              (resetn),
        .lane_valid          (lane_valid),
        .lane_in_delayslot   (lane_ds),
        .lane_except         (lane_exc),
        .lane_pc             (lane_pc),
        .lane_daddr          (lane_daddr),
        .cp0_status          (cp0_status),
        .cp0_cause           (cp0_cause),
        .cp0_epc             (cp0_epc),
        .redirect_ready      (redirect_ready),
        .lane_kill           (kill4),
        .busy                (busy4),
        .except_valid        (ev4),
        .except_code         (code4),
        .except_lane         (lane4),
        .except_inst_addr    (ia4),
        .except_epc          (epc4),
        .except_bad_addr     (bad4),
        .except_bad_addr_we  (we4),
        .except_in_delayslot (bd4),
        .except_target       (tgt4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Which lane would fault this cycle for an n-lane arbiter, and how.
    task automatic resolve(input int n, output bit found, output int win, output int code,
                           output bit we, output logic [31:0] badv);
        int first_valid;
        found = 0; win = 0; code = 0; we = 0; badv = '0;
        first_valid = -1;
        for (int i = n - 1; i >= 0; i--) if (lane_valid[i]) first_valid = i;
        for (int i = 0; i < n; i++) begin
            bit older_all;
            logic [7:0] e;
            older_all = 1;
            for (int j = 0; j < i; j++) older_all &= lane_valid[j];
            e = lane_exc[i*8 +: 8];
            if (!found && lane_valid[i]) begin
                if (m_int && i == first_valid && older_all) begin
                    found = 1; win = i; code = 0;
                end else begin
                    for (int k = 0; k < 8; k++) begin
                        if (!found && e[pri_bit[k]]) begin
                            found = 1; win = i; code = pri_code[k];
                            if (k < 3) begin
                                we   = 1;
                                badv = (k == 0) ? lane_pc[i*32 +: 32] : lane_daddr[i*32 +: 32];
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_dut(input int d, input logic [3:0] kill, input logic bsy, input logic ev,
                             input logic [4:0] code, input logic [1:0] lane, input logic [31:0] ia,
                             input logic [31:0] epc, input logic [31:0] badv, input logic we,
                             input logic bd, input logic [31:0] tgt, input bit found, input int win,
                             input int rcode, input bit rwe, input logic [31:0] rbad);
        string p;
        int n;
        logic [3:0] ek;
        logic [31:0] pcw;
        p  = (d == 0) ? "n2" : "n4";
        n  = (d == 0) ? 2 : 4;
        ek = '0;
        if (!m_hold[d] && found)
            for (int j = 0; j < n; j++) if (j >= win) ek[j] = 1'b1;
        check_eq({p, "_kill"}, {28'd0, kill}, {28'd0, ek});
        check_eq({p, "_busy"}, {31'd0, bsy}, {31'd0, m_hold[d]});
        check_eq({p, "_valid"}, {31'd0, ev}, {31'd0, m_valid[d]});
        if (m_valid[d]) begin
            check_eq({p, "_code"}, {27'd0, code}, m_code[d]);
            check_eq({p, "_lane"}, {30'd0, lane}, m_lane[d]);
            check_eq({p, "_inst_addr"}, ia, m_pc[d]);
            check_eq({p, "_epc"}, epc, m_epc[d]);
            check_eq({p, "_bd"}, {31'd0, bd}, {31'd0, m_bd[d]});
            check_eq({p, "_bad_we"}, {31'd0, we}, {31'd0, m_we[d]});
            if (m_we[d]) check_eq({p, "_bad_addr"}, badv, m_bad[d]);
            check_eq({p, "_target"}, tgt, m_tgt[d]);
        end
        if (!m_hold[d]) begin
            if (found) begin
                pcw         = lane_pc[win*32 +: 32];
                m_hold[d]   = 1;
                m_valid[d]  = 1;
                m_code[d]   = rcode;
                m_lane[d]   = win;
                m_pc[d]     = pcw;
                m_bd[d]     = lane_ds[win];
                m_epc[d]    = lane_ds[win] ? pcw - 32'd4 : pcw;
                m_we[d]     = rwe;
                m_bad[d]    = rbad;
                m_tgt[d]    = (rcode == 14) ? cp0_epc : (cp0_status[22] ? VB : VN);
            end
        end else if (redirect_ready) begin
            m_hold[d]  = 0;
            m_valid[d] = 0;
        end
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step();
        bit          f[2];
        int          w[2], c[2];
        bit          we[2];
        logic [31:0] bv[2];
        #1;
        resolve(2, f[0], w[0], c[0], we[0], bv[0]);
        resolve(4, f[1], w[1], c[1], we[1], bv[1]);
        check_dut(0, {2'b00, kill2}, busy2, ev2, code2, {1'b0, lane2}, ia2, epc2, bad2, we2, bd2,
                  tgt2, f[0], w[0], c[0], we[0], bv[0]);
        check_dut(1, kill4, busy4, ev4, code4, lane4, ia4, epc4, bad4, we4, bd4,
                  tgt4, f[1], w[1], c[1], we[1], bv[1]);
        m_int = ((cp0_cause[15:8] & cp0_status[15:8]) != 8'h00) && !cp0_status[1] && cp0_status[0];
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        check_eq("rst_valid2", {31'd0, ev2}, 32'd0);
        check_eq("rst_busy2", {31'd0, busy2}, 32'd0);
        check_eq("rst_kill2", {30'd0, kill2}, 32'd0);
        check_eq("rst_code2", {27'd0, code2}, 32'd0);
        check_eq("rst_target2", tgt2, 32'd0);
        check_eq("rst_epc2", epc2, 32'd0);
        check_eq("rst_valid4", {31'd0, ev4}, 32'd0);
        check_eq("rst_busy4", {31'd0, busy4}, 32'd0);
        check_eq("rst_kill4", {28'd0, kill4}, 32'd0);
        check_eq("rst_lane4", {30'd0, lane4}, 32'd0);
        m_int = 0;
        for (int d = 0; d < 2; d++) begin
            m_hold[d]  = 0;
            m_valid[d] = 0;
        end
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic drain();
        lane_valid     = '0;
        lane_exc       = '0;
        redirect_ready = 1'b1;
        step();
        step();
        redirect_ready = 1'b0;
    endtask

    initial begin
        resetn         = 1'b1;
        lane_valid     = '0;
        lane_ds        = '0;
        lane_exc       = '0;
        lane_pc        = '0;
        lane_daddr     = '0;
        cp0_status     = 32'h00400000;
        cp0_cause      = '0;
        cp0_epc        = '0;
        redirect_ready = 1'b0;
        #1;
        do_reset();

        // Load AdEL on lane 0 with BEV set.
        lane_valid          = 4'b0001;
        lane_exc[7:0]       = 8'h02;
        lane_pc[31:0]       = 32'h1000;
        lane_daddr[31:0]    = 32'h2003;
        #1;
        check_eq("t1_kill", {30'd0, kill2}, 32'h3);
        step();
        check_eq("t1_code", {27'd0, code2}, 32'h04);
        check_eq("t1_bad", bad2, 32'h2003);
        check_eq("t1_target", tgt2, 32'hBFC00380);
        drain();

        // Sys in lane 1's delay slot, lane 0 clean, BEV clear.
        cp0_status       = 32'h0;
        lane_valid       = 4'b0011;
        lane_ds          = 4'b0010;
        lane_exc[15:8]   = 8'h40;
        lane_pc[63:32]   = 32'h1008;
        #1;
        check_eq("t2_kill", {30'd0, kill2}, 32'h2);
        step();
        check_eq("t2_lane", {31'd0, lane2}, 32'd1);
        check_eq("t2_epc", epc2, 32'h1004);
        check_eq("t2_target", tgt2, 32'h80000180);
        lane_ds = '0;
        drain();

        // Interrupt waits for a valid lane 0.
        cp0_status = 32'h0000FF01;
        cp0_cause  = 32'h00000400;
        for (int c = 0; c < 5; c++) step();
        lane_valid = 4'b0001;
        step();
        check_eq("t3_valid", {31'd0, ev2}, 32'd1);
        check_eq("t3_code", {27'd0, code2}, 32'h00);
        cp0_status = 32'h00400000;
        cp0_cause  = 32'h0;
        drain();
        step();

        // ERET held while redirect is not ready.
        cp0_epc       = 32'h80000400;
        lane_valid    = 4'b0001;
        lane_exc[7:0] = 8'h10;
        step();
        lane_valid     = 4'b0011;
        lane_exc[15:8] = 8'h40;
        cp0_epc        = 32'h12345678;
        for (int c = 0; c < 3; c++) begin
            check_eq("t4_target", tgt2, 32'h80000400);
            check_eq("t4_busy", {31'd0, busy2}, 32'd1);
            step();
        end
        redirect_ready = 1'b1;
        step();
        check_eq("t4_dropped", {31'd0, ev2}, 32'd0);
        drain();

        // Reset in the middle of a hold, then a fresh capture.
        lane_valid    = 4'b0001;
        lane_exc[7:0] = 8'h04;
        step();
        step();
        do_reset();
        lane_exc[7:0] = 8'h08;
        step();
        check_eq("t5_code", {27'd0, code2}, 32'h0a);
        drain();

        // Four lanes: Ov on lane 2 and RI on lane 3.
        lane_valid = 4'b1111;
        lane_exc   = {8'h08, 8'h04, 8'h00, 8'h00};
        #1;
        check_eq("t6_kill", {28'd0, kill4}, 32'hC);
        step();
        check_eq("t6_lane", {30'd0, lane4}, 32'd2);
        check_eq("t6_code", {27'd0, code4}, 32'h0c);
        drain();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            lane_valid = 4'($urandom_range(0, 15));
            lane_ds    = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                lane_exc[i*8 +: 8]   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                lane_pc[i*32 +: 32]  = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
                lane_daddr[i*32 +: 32] = $urandom;
            end
            cp0_status     = {9'd0, 1'($urandom), 6'd0, 8'($urandom), 6'd0,
                              1'($urandom_range(0, 3) == 0), 1'($urandom)};
            cp0_cause      = ($urandom_range(0, 3) == 0) ? {16'd0, 8'($urandom), 8'd0} : 32'h0;
            cp0_epc        = $urandom;
            redirect_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            else step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exception_arbiter_n.md
Name: exception_arbiter_n

Overview:
- Registered, parametrised commit-stage exception arbiter for the N-issue MIPS pipeline.
- Resolves per-lane exception vectors in program order (lane 0 oldest) and attaches pending interrupts to the oldest valid lane.
- Computes ExcCode, EPC, BadVAddr and vector target, and kills younger lanes.
- Holds the resolved exception until the fetch/redirect logic accepts it, through a valid/ready handshake.

Parameters:
- NUM_LANES, 2, issue lanes arbitrated; lane 0 is the oldest.
- EXC_W, 8, per-lane exception flag width; bit map is fixed in the shared package.
- VEC_BEV, 32'hBFC00380, general exception vector when Status.BEV=1.
- VEC_NORMAL, 32'h80000180, general exception vector when Status.BEV=0.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; asynchronous, active-low.
- lane_valid  in  NUM_LANES  lane holds a committing instruction.
- lane_in_delayslot  in  NUM_LANES  lane instruction sits in a branch delay slot.
- lane_except  in  NUM_LANES*EXC_W  per-lane flags; lane i uses bits [i*EXC_W +: EXC_W].
- lane_pc  in  NUM_LANES*32  per-lane PC.
- lane_daddr  in  NUM_LANES*32  per-lane data address.
- cp0_status  in  32  CP0 Status.
- cp0_cause  in  32  CP0 Cause.
- cp0_epc  in  32  CP0 EPC.
- redirect_ready  in  1  fetch/redirect logic accepts the exception.
- lane_kill  out  NUM_LANES  combinational; squash lane this cycle.
- busy  out  1  arbiter is holding an exception; pipeline stalls commit.
- except_valid  out  1  resolved exception is presented.
- except_code  out  5  MIPS ExcCode; 5'h0e means ERET.
- except_lane  out  $clog2(NUM_LANES) (min 1)  lane that faulted.
- except_inst_addr  out  32  faulting PC.
- except_epc  out  32  value to write into EPC.
- except_bad_addr  out  32  BadVAddr value.
- except_bad_addr_we  out  1  BadVAddr must be written.
- except_in_delayslot  out  1  value for Cause.BD.
- except_target  out  32  redirect PC.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, int_req_q=0. All registered outputs are 0: except_valid, except_code, except_lane, addresses, flags, target. busy=0 and lane_kill=0. Reset mid-HOLD aborts the exception with no ready needed.
- Interrupt request:
  - Registered every cycle: int_req_q <= ((cause[15:8] & status[15:8]) != 0) && !status[1] && status[0].
  - It attaches to the lowest-index valid lane, and only when that lane is lane 0 or every lower lane is valid.
  - With no valid lane, the request waits; it is never dropped while asserted.
- Per-lane priority (highest first), with ExcCode and BadVAddr:
  - Interrupt: 0x00.
  - bit7 fetch AdEL: 0x04, bad=lane_pc.
  - bit1 load AdEL: 0x04, bad=lane_daddr.
  - bit0 store AdES: 0x05, bad=lane_daddr.
  - bit6 Sys: 0x08.
  - bit5 Bp: 0x09.
  - bit4 ERET: 0x0e.
  - bit3 RI: 0x0a.
  - bit2 Ov: 0x0c.
- Lane selection:
  - The winning lane is the lowest-index valid lane with any hit; only valid lanes are considered.
  - lane_kill[j]=1 for every j >= the winning lane, combinationally in the same cycle, in IDLE only.
- except_bad_addr_we=1 only for the AdEL/AdES rows.
- except_epc = in_delayslot ? pc-32'd4 : pc, using 32-bit wrap-around; pc=0 in a delay slot gives 32'hFFFFFFFC.
- except_target:
  - ERET: cp0_epc, sampled in the winning cycle.
  - Otherwise: status[22] ? VEC_BEV : VEC_NORMAL.
- FSM:
  - IDLE: on a winning lane, register all outputs, set except_valid=1, go to HOLD. Latency is 1 cycle from inputs to outputs.
  - HOLD: busy=1. Outputs are frozen; lane inputs and CP0 changes are ignored and lane_kill=0. On redirect_ready=1 the exception completes: next edge except_valid=0, go to IDLE.
  - Completion in the cycle of capture is not possible; minimum HOLD is 1 cycle.
  - Back-to-back exceptions: the first IDLE cycle after HOLD may capture a new exception. There is no bubble beyond that.
- int_req_q is not cleared by the arbiter. The handler sets EXL, which drops the request on the next sample.
- Simultaneous interrupt and a lane exception in a later lane: the interrupt wins on the oldest valid lane.

Decomposition:
- Shared package exc_pkg holds:
  - EXC bit indices (EXC_IF_ADEL=7, SYS=6, BP=5, ERET=4, RI=3, OV=2, LD_ADEL=1, ST_ADES=0).
  - ExcCode localparams.
  - typedef enum {IDLE, HOLD} exc_state_t.
  - struct exc_info_t {code, epc, bad_addr, bad_we, bd, target}.
- One sub-module, exc_lane_decode: purely combinational per-lane priority encoder producing hit + exc_info_t. It is instantiated NUM_LANES times via generate.

Test Plan:
- Lane0 valid, except=8'h02, pc=0x1000, daddr=0x2003, BEV=1 -> next cycle: valid=1, code=0x04, bad=0x2003, we=1, target=0xBFC00380, epc=0x1000, lane_kill=2'b11.
- Lane0 clean; lane1 except=8'h40 (Sys), in_delayslot=1, pc=0x1008, BEV=0 -> code=0x08, lane=1, epc=0x1004, bd=1, target=0x80000180, lane_kill=2'b10.
- Status=0x0000FF01, cause IP2 set, lane0 invalid then valid at cycle 5 -> no exception until cycle 5; code=0x00 captured at edge 6.
- Lane0 ERET with cp0_epc=0x8000_0400, redirect_ready low 3 cycles -> outputs held 4 cycles, busy=1, target=0x80000400, kill=0 during HOLD; ready high -> valid drops next edge.
- resetn pulsed low mid-HOLD -> outputs and busy go 0 asynchronously; after release, a new exception is captured normally.
- NUM_LANES=4, except on lanes 2 and 3 simultaneously (Ov, RI) -> lane=2, code=0x0c, lane_kill=4'b1100.
